// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage. Owns the PC, fetches one word at a time from
// instruction memory over a req/gnt/rvalid handshake, and presents
// {IF_PC, IF_Instruction} to the IF/ID pipeline register.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall             IF/ID is holding; the output slot is not taken
//   redirect_en/_pc   taken branch/jump from EX; reloads the PC
//   imem_req/_addr    fetch request and byte address (bits [1:0] = 0)
//   imem_gnt          request accepted this cycle
//   imem_rvalid/_rdata returned instruction word, at least 1 cycle after gnt
//   IF_PC             PC of the presented instruction
//   IF_Instruction    presented instruction, NOP_INSTR when not valid
//   if_valid          output slot holds a real instruction
//   fetch_err         misaligned redirect flag
//
// Build option:
//   IF_MISALIGN_CHK_EN  when defined, a redirect target with non-zero low
//                       bits is reported on fetch_err instead of fetched,
//                       and the stage idles until the next redirect. When
//                       undefined the low bits are masked and fetch_err
//                       stays 0.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | no request outstanding; request pc_q when there is room
// WAIT  | request granted, waiting for rvalid (kill_q = drop that word)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int              PC_W      = 12,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] IF_PC,
    output logic [31:0]     IF_Instruction,
    output logic            if_valid,
    output logic            fetch_err
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic            out_valid_q, out_valid_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            skid_valid_q, skid_valid_d;
    logic            kill_q, kill_d;
    logic            err_q, err_d;

    logic            req_ok;
    logic            issue;
    logic            consume;
    logic            capture;
    logic            misalign;
    logic [PC_W-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc[PC_W-1:2], 2'b00};

`ifdef IF_MISALIGN_CHK_EN
    assign misalign = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];
    assign misalign           = 1'b0;
`endif

    // A request only goes out when the word it returns is guaranteed a home:
    // skid empty and the output slot either empty or being taken this cycle.
    assign req_ok   = (state_q == ST_FETCH) && !skid_valid_q
                      && (!out_valid_q || !stall) && !err_q;
    assign imem_req = req_ok && rst_n;
    assign issue    = req_ok && imem_gnt;
    // A reported misalignment is held until the next redirect.
    assign consume  = out_valid_q && !stall && !err_q;
    assign capture  = (state_q == ST_WAIT) && imem_rvalid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        out_valid_d  = out_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_valid_d = skid_valid_q;
        kill_d       = kill_q;
        err_d        = err_q;

        if (redirect_en) begin
            pc_d         = redirect_pc_aligned;
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            skid_valid_d = 1'b0;
            err_d        = 1'b0;
            // A request still in flight must have its response discarded.
            if (((state_q == ST_WAIT) && !imem_rvalid) || issue) begin
                kill_d  = 1'b1;
                state_d = ST_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = ST_FETCH;
            end
            if (misalign) begin
                out_valid_d = 1'b1;
                out_pc_d    = redirect_pc;
                err_d       = 1'b1;
            end
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    out_pc_d     = skid_pc_q;
                    out_instr_d  = skid_instr_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                    out_instr_d = NOP_INSTR;
                end
            end

            if (issue) begin
                state_d = ST_WAIT;
            end

            if (capture) begin
                state_d = ST_FETCH;
                if (kill_q) begin
                    kill_d = 1'b0;
                end else begin
                    pc_d = pc_q + PC_INC;
                    if (!out_valid_q || (consume && !skid_valid_q)) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = imem_rdata;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            out_pc_q     <= RESET_PC;
            out_instr_q  <= NOP_INSTR;
            out_valid_q  <= 1'b0;
            skid_pc_q    <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            kill_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            out_valid_q  <= out_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_valid_q <= skid_valid_d;
            kill_q       <= kill_d;
            err_q        <= err_d;
        end
    end

    // pc_q is frozen from grant until rvalid, so the address stays stable.
    assign imem_addr      = pc_q;
    assign IF_PC          = out_pc_q;
    assign IF_Instruction = out_instr_q;
    assign if_valid       = out_valid_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: a word memory with random grant and
// latency, and a reference model that tracks the in-order PC stream,
// the number of words held by the stage, and the next fetch address.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [11:0] redirect_pc = 12'h000;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [11:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        if_valid;
    logic        fetch_err;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .IF_PC         (IF_PC),
        .IF_Instruction(IF_Instruction),
        .if_valid      (if_valid),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // memory and reference model
    logic [31:0] mem [0:1023];
    int          cyc;
    int          gnt_pct;
    int          lat_fix;
    int          lat_max;
    bit          pend_valid;
    bit          pend_live;
    logic [11:0] pend_addr;
    int          pend_due;
    int          buffered;
    logic [11:0] exp_pc;
    logic [11:0] exp_fetch;

    // per-cycle observations and expectations
    bit          s_cons, s_gnt;
    logic        o_req, e_req, o_valid, e_valid, o_err;
    logic [11:0] o_cpc, e_cpc, o_gaddr, e_gaddr;
    logic [31:0] o_cins, e_cins, o_ins;

    task automatic model_reset(input logic [11:0] pc);
        buffered   = 0;
        pend_valid = 0;
        pend_live  = 0;
        exp_pc     = pc;
        exp_fetch  = pc;
    endtask

    // One clock: starts and ends at a falling edge.
    task automatic step(input logic st, input logic rd, input logic [11:0] rpc);
        int lat;
        stall       = st;
        redirect_en = rd;
        redirect_pc = rpc;
        imem_rvalid = pend_valid && (cyc == pend_due);
        imem_rdata  = imem_rvalid ? mem[pend_addr[11:2]] : 32'($urandom);
        #1;
        imem_gnt = imem_req && (int'($urandom_range(99, 0)) < gnt_pct);
        #1;
        o_req   = imem_req;
        o_valid = if_valid;
        o_ins   = IF_Instruction;
        o_err   = fetch_err;
        e_req   = !pend_valid && (buffered == 0 || (buffered == 1 && !st));
        e_valid = (buffered != 0);
        s_cons  = (buffered != 0) && !st && !rd;
        if (s_cons) begin
            o_cpc  = IF_PC;
            e_cpc  = exp_pc;
            o_cins = IF_Instruction;
            e_cins = mem[exp_pc[11:2]];
            exp_pc = exp_pc + 12'd4;
            buffered--;
        end
        if (imem_rvalid) begin
            if (pend_live) buffered++;
            pend_valid = 0;
        end
        s_gnt = imem_gnt;
        if (s_gnt) begin
            o_gaddr    = imem_addr;
            e_gaddr    = exp_fetch;
            exp_fetch  = exp_fetch + 12'd4;
            lat        = (lat_fix != 0) ? lat_fix : int'($urandom_range(lat_max, 1));
            pend_valid = 1;
            pend_live  = 1;
            pend_addr  = imem_addr;
            pend_due   = cyc + lat;
        end
        if (rd) begin
            pend_live = 0;
            buffered  = 0;
            exp_pc    = rpc & 12'hFFC;
            exp_fetch = exp_pc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk += 6;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        if (imem_addr !== 12'h000) begin n_fail++; $display("FAIL rst_addr got=%h exp=000", imem_addr); end
        if (IF_PC !== 12'h000) begin n_fail++; $display("FAIL rst_pc got=%h exp=000", IF_PC); end
        if (IF_Instruction !== NOP) begin n_fail++; $display("FAIL rst_instr got=%h exp=%h", IF_Instruction, NOP); end
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
        model_reset(12'h000);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_zero_wait();
        int          gc[$];
        logic [11:0] ga[$];
        logic [31:0] first_ins;
        bit          got_first;
        int          c;
        got_first = 0;
        first_ins = 32'h0;
        gnt_pct = 100;
        lat_fix = 1;
        for (int i = 0; i < 12; i++) begin
            c = cyc;
            step(1'b0, 1'b0, 12'h000);
            n_chk += 2;
            if (o_req !== e_req) begin n_fail++; $display("FAIL zw_req cyc=%0d got=%b exp=%b", c, o_req, e_req); end
            if (o_valid !== e_valid) begin n_fail++; $display("FAIL zw_valid cyc=%0d got=%b exp=%b", c, o_valid, e_valid); end
            if (!o_valid) begin
                n_chk++;
                if (o_ins !== NOP) begin n_fail++; $display("FAIL zw_bubble cyc=%0d got=%h exp=%h", c, o_ins, NOP); end
            end
            if (s_cons) begin
                n_chk += 2;
                if (o_cpc !== e_cpc) begin n_fail++; $display("FAIL zw_pc cyc=%0d got=%h exp=%h", c, o_cpc, e_cpc); end
                if (o_cins !== e_cins) begin n_fail++; $display("FAIL zw_ins cyc=%0d got=%h exp=%h", c, o_cins, e_cins); end
                if (!got_first) begin got_first = 1; first_ins = o_cins; end
            end
            if (s_gnt) begin
                gc.push_back(c);
                ga.push_back(o_gaddr);
            end
        end
        n_chk++;
        if (gc.size() < 3) begin
            n_fail++; $display("FAIL zw_gnt_count got=%0d exp>=3", gc.size());
        end else begin
            n_chk += 5;
            if (ga[0] !== 12'h000) begin n_fail++; $display("FAIL zw_addr0 got=%h exp=000", ga[0]); end
            if (ga[1] !== 12'h004) begin n_fail++; $display("FAIL zw_addr1 got=%h exp=004", ga[1]); end
            if (ga[2] !== 12'h008) begin n_fail++; $display("FAIL zw_addr2 got=%h exp=008", ga[2]); end
            if (gc[1] - gc[0] != 2) begin n_fail++; $display("FAIL zw_rate01 got=%0d exp=2", gc[1] - gc[0]); end
            if (gc[2] - gc[1] != 2) begin n_fail++; $display("FAIL zw_rate12 got=%0d exp=2", gc[2] - gc[1]); end
        end
        n_chk++;
        if (first_ins !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_first_ins got=%h exp=deadbeef", first_ins); end
    endtask

    task automatic test_stall_skid();
        int  n;
        gnt_pct = 100;
        lat_fix = 1;
        n = 0;
        s_gnt = 0;
        while (!s_gnt && n < 20) begin step(1'b0, 1'b0, 12'h000); n++; end
        n_chk++;
        if (!s_gnt) begin n_fail++; $display("FAIL st_gnt_timeout got=0 exp=1"); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 12'h000);
            n_chk += 2;
            if (o_req !== e_req) begin n_fail++; $display("FAIL st_req i=%0d got=%b exp=%b", i, o_req, e_req); end
            if (o_valid !== e_valid) begin n_fail++; $display("FAIL st_valid i=%0d got=%b exp=%b", i, o_valid, e_valid); end
            if (i > 0) begin
                n_chk += 2;
                if (o_req !== 1'b0) begin n_fail++; $display("FAIL st_req_held i=%0d got=%b exp=0", i, o_req); end
                if (o_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid_held i=%0d got=%b exp=1", i, o_valid); end
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 12'h000);
            n_chk += 2;
            if (o_req !== e_req) begin n_fail++; $display("FAIL st2_req i=%0d got=%b exp=%b", i, o_req, e_req); end
            if (o_valid !== e_valid) begin n_fail++; $display("FAIL st2_valid i=%0d got=%b exp=%b", i, o_valid, e_valid); end
            if (s_cons) begin
                n_chk += 2;
                if (o_cpc !== e_cpc) begin n_fail++; $display("FAIL st2_pc i=%0d got=%h exp=%h", i, o_cpc, e_cpc); end
                if (o_cins !== e_cins) begin n_fail++; $display("FAIL st2_ins i=%0d got=%h exp=%h", i, o_cins, e_cins); end
            end
            if (s_gnt) begin
                n_chk++;
                if (o_gaddr !== e_gaddr) begin n_fail++; $display("FAIL st2_addr i=%0d got=%h exp=%h", i, o_gaddr, e_gaddr); end
            end
        end
    endtask

    task automatic test_redirect_kill();
        int  n;
        bit  seen;
        gnt_pct = 100;
        lat_fix = 3;
        n = 0;
        s_gnt = 0;
        while (!s_gnt && n < 20) begin step(1'b0, 1'b0, 12'h000); n++; end
        n_chk++;
        if (!s_gnt) begin n_fail++; $display("FAIL rk_gnt_timeout got=0 exp=1"); end
        mem[o_gaddr[11:2]] = 32'h11111111;
        step(1'b0, 1'b1, 12'h100);
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            step(1'b0, 1'b0, 12'h000);
            n++;
            n_chk += 2;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rk_valid n=%0d got=%b exp=0", n, o_valid); end
            if (o_req !== e_req) begin n_fail++; $display("FAIL rk_req n=%0d got=%b exp=%b", n, o_req, e_req); end
            if (s_gnt) begin
                seen = 1;
                n_chk++;
                if (o_gaddr !== 12'h100) begin n_fail++; $display("FAIL rk_addr got=%h exp=100", o_gaddr); end
            end
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL rk_refetch_timeout got=0 exp=1"); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 12'h000);
            n_chk++;
            if (o_valid !== e_valid) begin n_fail++; $display("FAIL rk2_valid i=%0d got=%b exp=%b", i, o_valid, e_valid); end
            if (s_cons) begin
                n_chk += 2;
                if (o_cpc !== e_cpc) begin n_fail++; $display("FAIL rk2_pc i=%0d got=%h exp=%h", i, o_cpc, e_cpc); end
                if (o_cins !== e_cins) begin n_fail++; $display("FAIL rk2_ins i=%0d got=%h exp=%h", i, o_cins, e_cins); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] ga[$];
        int          n;
        gnt_pct = 100;
        lat_fix = 1;
        step(1'b0, 1'b1, 12'hFFC);
        n = 0;
        while (ga.size() < 2 && n < 30) begin
            step(1'b0, 1'b0, 12'h000);
            n++;
            if (s_cons) begin
                n_chk += 2;
                if (o_cpc !== e_cpc) begin n_fail++; $display("FAIL wr_pc got=%h exp=%h", o_cpc, e_cpc); end
                if (o_cins !== e_cins) begin n_fail++; $display("FAIL wr_ins got=%h exp=%h", o_cins, e_cins); end
            end
            if (s_gnt) ga.push_back(o_gaddr);
        end
        n_chk++;
        if (ga.size() < 2) begin
            n_fail++; $display("FAIL wr_gnt_count got=%0d exp=2", ga.size());
        end else begin
            n_chk += 2;
            if (ga[0] !== 12'hFFC) begin n_fail++; $display("FAIL wr_addr0 got=%h exp=ffc", ga[0]); end
            if (ga[1] !== 12'h000) begin n_fail++; $display("FAIL wr_addr1 got=%h exp=000", ga[1]); end
        end
    endtask

    task automatic test_random();
        logic        st, rd;
        logic [11:0] rpc;
        int          n_cons;
        gnt_pct = 70;
        lat_fix = 0;
        lat_max = 4;
        n_cons  = 0;
        for (int i = 0; i < 500; i++) begin
            st  = ($urandom_range(99, 0) < 30);
            rd  = ($urandom_range(99, 0) < 3);
            rpc = 12'($urandom_range(4095, 0));
`ifdef IF_MISALIGN_CHK_EN
            rpc = rpc & 12'hFFC;
`endif
            step(st, rd, rpc);
            n_chk += 3;
            if (o_req !== e_req) begin n_fail++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, o_req, e_req); end
            if (o_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, o_valid, e_valid); end
            if (o_err !== 1'b0) begin n_fail++; $display("FAIL rnd_err i=%0d got=%b exp=0", i, o_err); end
            if (!o_valid) begin
                n_chk++;
                if (o_ins !== NOP) begin n_fail++; $display("FAIL rnd_bubble i=%0d got=%h exp=%h", i, o_ins, NOP); end
            end
            if (s_cons) begin
                n_cons++;
                n_chk += 2;
                if (o_cpc !== e_cpc) begin n_fail++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, o_cpc, e_cpc); end
                if (o_cins !== e_cins) begin n_fail++; $display("FAIL rnd_ins i=%0d got=%h exp=%h", i, o_cins, e_cins); end
            end
            if (s_gnt) begin
                n_chk++;
                if (o_gaddr !== e_gaddr) begin n_fail++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, o_gaddr, e_gaddr); end
            end
        end
        n_chk++;
        if (n_cons < 50) begin n_fail++; $display("FAIL rnd_progress got=%0d exp>=50", n_cons); end
    endtask

    task automatic test_reset_mid_wait();
        int  n;
        bit  seen;
        gnt_pct = 100;
        lat_fix = 3;
        n = 0;
        s_gnt = 0;
        while (!s_gnt && n < 30) begin step(1'b0, 1'b0, 12'h000); n++; end
        n_chk++;
        if (!s_gnt) begin n_fail++; $display("FAIL rmw_gnt_timeout got=0 exp=1"); end
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        stall       = 1'b0;
        redirect_en = 1'b0;
        imem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        n_chk += 6;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmw_req got=%b exp=0", imem_req); end
        if (imem_addr !== 12'h000) begin n_fail++; $display("FAIL rmw_addr got=%h exp=000", imem_addr); end
        if (IF_PC !== 12'h000) begin n_fail++; $display("FAIL rmw_pc got=%h exp=000", IF_PC); end
        if (IF_Instruction !== NOP) begin n_fail++; $display("FAIL rmw_instr got=%h exp=%h", IF_Instruction, NOP); end
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_valid got=%b exp=0", if_valid); end
        if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rmw_err got=%b exp=0", fetch_err); end
        rst_n = 1'b1;
        model_reset(12'h000);
        lat_fix = 1;
        seen = 0;
        n = 0;
        while (n < 10) begin
            step(1'b0, 1'b0, 12'h000);
            n++;
            n_chk++;
            if (o_valid !== e_valid) begin n_fail++; $display("FAIL rmw2_valid n=%0d got=%b exp=%b", n, o_valid, e_valid); end
            if (s_gnt && !seen) begin
                seen = 1;
                n_chk++;
                if (o_gaddr !== 12'h000) begin n_fail++; $display("FAIL rmw_first_addr got=%h exp=000", o_gaddr); end
            end
            if (s_cons) begin
                n_chk++;
                if (o_cpc !== e_cpc) begin n_fail++; $display("FAIL rmw2_pc got=%h exp=%h", o_cpc, e_cpc); end
            end
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL rmw_refetch_timeout got=0 exp=1"); end
    endtask

`ifdef IF_MISALIGN_CHK_EN
    task automatic test_misalign();
        int  n;
        bit  seen;
        gnt_pct = 0;
        n = 0;
        while (pend_valid && n < 20) begin step(1'b0, 1'b0, 12'h000); n++; end
        stall       = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 12'h102;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        redirect_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            #1;
            n_chk += 5;
            if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL ma_err i=%0d got=%b exp=1", i, fetch_err); end
            if (IF_PC !== 12'h102) begin n_fail++; $display("FAIL ma_pc i=%0d got=%h exp=102", i, IF_PC); end
            if (IF_Instruction !== NOP) begin n_fail++; $display("FAIL ma_instr i=%0d got=%h exp=%h", i, IF_Instruction, NOP); end
            if (if_valid !== 1'b1) begin n_fail++; $display("FAIL ma_valid i=%0d got=%b exp=1", i, if_valid); end
            if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ma_req i=%0d got=%b exp=0", i, imem_req); end
            @(posedge clk);
            @(negedge clk);
        end
        gnt_pct = 100;
        lat_fix = 1;
        model_reset(12'h000);
        step(1'b0, 1'b1, 12'h200);
        seen = 0;
        n = 0;
        while (!seen && n < 10) begin
            step(1'b0, 1'b0, 12'h000);
            n++;
            n_chk++;
            if (o_err !== 1'b0) begin n_fail++; $display("FAIL ma_err_clr got=%b exp=0", o_err); end
            if (s_gnt) begin
                seen = 1;
                n_chk++;
                if (o_gaddr !== 12'h200) begin n_fail++; $display("FAIL ma_addr got=%h exp=200", o_gaddr); end
            end
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL ma_refetch_timeout got=0 exp=1"); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'hDEADBEEF;
        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        gnt_pct = 100;
        lat_fix = 1;
        lat_max = 4;
        model_reset(12'h000);
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_redirect_kill();
        test_wrap();
        test_random();
        test_reset_mid_wait();
`ifdef IF_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

endmodule
